// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the memory-init master state type.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam int HRESP_ERROR = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WDRAIN,
        ST_READ,
        ST_RDRAIN,
        ST_FINISH
    } minit_state_t;

endpackage

// File: rtl/ahbl_minit_pattern.sv
// Fill pattern generator: constant seed, or seed plus the word index.
module ahbl_minit_pattern #(
    parameter int CNT_W = 16
) (
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] idx,
    input  logic             incr,
    output logic [31:0]      pattern
);

    assign pattern = incr ? (seed + 32'(idx)) : seed;

endmodule

// File: rtl/ahbl_mem_init_master.sv
// AHB-Lite master that fills a word region with a pattern and optionally
// reads it back, flagging the first bus error or compare mismatch.
module ahbl_mem_init_master
    import ahbl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             start,
    input  logic             verify,
    input  logic             incr,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_words,
    input  logic [31:0]      seed,
    output logic             busy,
    output logic             done,
    output logic             err_bus,
    output logic             err_cmp,
    output logic [31:0]      fail_addr,
    output logic [31:0]      fail_data,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic [2:0]       HBURST,
    output logic [2:0]       HSIZE,
    output logic             HWRITE,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic [1:0]       HRESP,
    input  logic [31:0]      HRDATA
);

    minit_state_t state, state_nxt;

    logic [31:0]      base_q;
    logic [31:0]      seed_q;
    logic [CNT_W-1:0] num_q;
    logic             verify_q;
    logic             incr_q;
    logic [CNT_W-1:0] addr_idx;
    logic [CNT_W-1:0] data_idx;
    logic             dp_valid;
    logic             dp_write;

    logic [31:0] wr_pattern;
    logic [31:0] exp_pattern;
    logic [31:0] addr_cur;
    logic [31:0] dp_addr;
    logic        addr_phase;
    logic        last_addr;
    logic        bus_err;
    logic        rd_mismatch;
    logic        unused_bits;

    assign unused_bits = ^{HRESP[1], base_addr[1:0]};

    ahbl_minit_pattern #(.CNT_W(CNT_W)) u_wr_pattern (
        .seed    (seed_q),
        .idx     (data_idx),
        .incr    (incr_q),
        .pattern (wr_pattern)
    );

    ahbl_minit_pattern #(.CNT_W(CNT_W)) u_cmp_pattern (
        .seed    (seed_q),
        .idx     (data_idx),
        .incr    (incr_q),
        .pattern (exp_pattern)
    );

    assign addr_phase  = (state == ST_WRITE) || (state == ST_READ);
    assign last_addr   = (addr_idx == (num_q - CNT_W'(1)));
    assign addr_cur    = base_q + (32'(addr_idx) << 2);
    assign dp_addr     = base_q + (32'(data_idx) << 2);
    // First cycle of a two-cycle ERROR response: HREADY is still low.
    assign bus_err     = dp_valid && !HREADY && HRESP[HRESP_ERROR];
    assign rd_mismatch = dp_valid && !dp_write && HREADY && (HRDATA != exp_pattern);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        HTRANS    = HTRANS_IDLE;
        HADDR     = '0;
        HWRITE    = 1'b0;
        HBURST    = HBURST_INCR;
        HSIZE     = HSIZE_WORD;
        HWDATA    = (dp_valid && dp_write) ? wr_pattern : '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (num_words == '0) ? ST_FINISH : ST_WRITE;
                end
            end
            ST_WRITE, ST_READ: begin
                busy   = 1'b1;
                HADDR  = addr_cur;
                HWRITE = (state == ST_WRITE);
                // Restart the burst at each 1 KB boundary.
                HTRANS = ((addr_idx == '0) || (addr_cur[9:0] == 10'd0)) ? HTRANS_NONSEQ : HTRANS_SEQ;
                if (bus_err) begin
                    state_nxt = ST_FINISH;
                end else if (HREADY && last_addr) begin
                    state_nxt = (state == ST_WRITE) ? ST_WDRAIN : ST_RDRAIN;
                end
            end
            ST_WDRAIN, ST_RDRAIN: begin
                busy   = 1'b1;
                HADDR  = addr_cur;
                HWRITE = (state == ST_WDRAIN);
                if (bus_err) begin
                    state_nxt = ST_FINISH;
                end else if (HREADY) begin
                    state_nxt = ((state == ST_WDRAIN) && verify_q) ? ST_READ : ST_FINISH;
                end
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            base_q    <= '0;
            seed_q    <= '0;
            num_q     <= '0;
            verify_q  <= 1'b0;
            incr_q    <= 1'b0;
            addr_idx  <= '0;
            data_idx  <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            err_bus   <= 1'b0;
            err_cmp   <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                base_q    <= {base_addr[31:2], 2'b00};
                seed_q    <= seed;
                num_q     <= num_words;
                verify_q  <= verify;
                incr_q    <= incr;
                addr_idx  <= '0;
                data_idx  <= '0;
                dp_valid  <= 1'b0;
                dp_write  <= 1'b0;
                err_bus   <= 1'b0;
                err_cmp   <= 1'b0;
                fail_addr <= '0;
                fail_data <= '0;
            end
        end else if (bus_err) begin
            err_bus  <= 1'b1;
            dp_valid <= 1'b0;
            if (!err_cmp) begin
                fail_addr <= dp_addr;
                fail_data <= '0;
            end
        end else if (HREADY) begin
            if (rd_mismatch && !err_cmp) begin
                err_cmp   <= 1'b1;
                fail_addr <= dp_addr;
                fail_data <= HRDATA;
            end
            dp_valid <= addr_phase;
            dp_write <= (state == ST_WRITE);
            if (addr_phase) begin
                data_idx <= addr_idx;
            end
            if (addr_phase && !last_addr) begin
                addr_idx <= addr_idx + CNT_W'(1);
            end
            // Read-back replays the address sequence from the first word.
            if (state == ST_WDRAIN) begin
                addr_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_mem_init_master.sv
// Directed self-checking bench for ahbl_mem_init_master with a small AHB slave model.
module tb_ahbl_mem_init_master;

    localparam int NCYC = 24;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start;
    logic        verify;
    logic        incr;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic        err_bus;
    logic        err_cmp;
    logic [31:0] fail_addr;
    logic [31:0] fail_data;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    int checks = 0;
    int errors = 0;
    int done_cyc;

    logic        rdy_plan  [0:NCYC-1];
    logic [1:0]  resp_plan [0:NCYC-1];
    logic [1:0]  obs_trans [0:NCYC-1];
    logic [31:0] obs_addr  [0:NCYC-1];
    logic [31:0] obs_wdata [0:NCYC-1];
    logic        obs_write [0:NCYC-1];
    logic        obs_busy  [0:NCYC-1];

    logic [31:0] mem [0:255];
    logic        sl_valid;
    logic        sl_write;
    logic [31:0] sl_addr;
    logic [31:0] bad_addr;

    always #5 HCLK = ~HCLK;

    ahbl_mem_init_master #(.CNT_W(16)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start     (start),
        .verify    (verify),
        .incr      (incr),
        .base_addr (base_addr),
        .num_words (num_words),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .err_bus   (err_bus),
        .err_cmp   (err_cmp),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA)
    );

    // Slave model: stores writes, returns them on reads, corrupts bad_addr.
    always @(posedge HCLK) begin
        if (HRESET) begin
            sl_valid <= 1'b0;
            sl_write <= 1'b0;
            sl_addr  <= '0;
        end else if (HREADY) begin
            if (sl_valid && sl_write) mem[sl_addr[9:2]] <= HWDATA;
            sl_valid <= HTRANS[1];
            sl_write <= HWRITE;
            sl_addr  <= HADDR;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (sl_valid && !sl_write) HRDATA = (sl_addr == bad_addr) ? 32'hDEADBEEF : mem[sl_addr[9:2]];
    end

    task automatic clear_plan();
        for (int c = 0; c < NCYC; c++) begin
            rdy_plan[c]  = 1'b1;
            resp_plan[c] = 2'b00;
        end
    endtask

    task automatic run_op(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s,
                          input logic v, input logic inc, input int restart_at);
        @(negedge HCLK);
        base_addr = b; num_words = n; seed = s; verify = v; incr = inc; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        done_cyc = -1;
        for (int c = 1; c < NCYC; c++) begin
            start = (c == restart_at);
            if (c == restart_at) base_addr = 32'h800;
            HREADY = rdy_plan[c];
            HRESP  = resp_plan[c];
            obs_trans[c] = HTRANS;
            obs_addr[c]  = HADDR;
            obs_wdata[c] = HWDATA;
            obs_write[c] = HWRITE;
            obs_busy[c]  = busy;
            if (done && done_cyc < 0) done_cyc = c;
            @(negedge HCLK);
        end
        start = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
        clear_plan();
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (2) @(negedge HCLK);
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("[TB] FAIL reset_htrans: got %b expected 00", HTRANS); end
        checks++; if (HADDR !== 32'h0) begin errors++; $display("[TB] FAIL reset_haddr: got %h expected 0", HADDR); end
        checks++; if (HWDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_hwdata: got %h expected 0", HWDATA); end
        checks++; if (HWRITE !== 1'b0) begin errors++; $display("[TB] FAIL reset_hwrite: got %b expected 0", HWRITE); end
        checks++; if (HBURST !== 3'b001) begin errors++; $display("[TB] FAIL reset_hburst: got %b expected 001", HBURST); end
        checks++; if (HSIZE !== 3'b010) begin errors++; $display("[TB] FAIL reset_hsize: got %b expected 010", HSIZE); end
        checks++; if ({busy, done, err_bus, err_cmp} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, done, err_bus, err_cmp}); end
        checks++; if ({fail_addr, fail_data} !== 64'h0) begin errors++; $display("[TB] FAIL reset_fail: got %h expected 0", {fail_addr, fail_data}); end
        HRESET = 1'b0;
        @(negedge HCLK);
    endtask

    task automatic test_fill();
        run_op(32'h100, 16'd4, 32'hA5A50000, 1'b0, 1'b1, -1);
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_addr[i+1] !== 32'h100 + 32'(4*i)) begin errors++; $display("[TB] FAIL fill_haddr%0d: got %h expected %h", i, obs_addr[i+1], 32'h100 + 32'(4*i)); end
            checks++; if (obs_trans[i+1] !== ((i == 0) ? 2'b10 : 2'b11)) begin errors++; $display("[TB] FAIL fill_htrans%0d: got %b", i, obs_trans[i+1]); end
            checks++; if (obs_wdata[i+2] !== 32'hA5A50000 + 32'(i)) begin errors++; $display("[TB] FAIL fill_hwdata%0d: got %h expected %h", i, obs_wdata[i+2], 32'hA5A50000 + 32'(i)); end
        end
        checks++; if (obs_write[1] !== 1'b1) begin errors++; $display("[TB] FAIL fill_hwrite: got %b expected 1", obs_write[1]); end
        checks++; if (obs_trans[5] !== 2'b00) begin errors++; $display("[TB] FAIL fill_drain_idle: got %b expected 00", obs_trans[5]); end
        checks++; if ({obs_busy[1], obs_busy[5], obs_busy[6]} !== 3'b110) begin errors++; $display("[TB] FAIL fill_busy: got %b expected 110", {obs_busy[1], obs_busy[5], obs_busy[6]}); end
        checks++; if (done_cyc !== 6) begin errors++; $display("[TB] FAIL fill_done_cycle: got %0d expected 6", done_cyc); end
        checks++; if ({err_bus, err_cmp} !== 2'b00) begin errors++; $display("[TB] FAIL fill_errs: got %b expected 00", {err_bus, err_cmp}); end
    endtask

    task automatic test_wait_states();
        rdy_plan[3] = 1'b0;
        rdy_plan[4] = 1'b0;
        run_op(32'h100, 16'd4, 32'hA5A50000, 1'b0, 1'b1, -1);
        for (int c = 3; c <= 5; c++) begin
            checks++; if (obs_addr[c] !== 32'h108) begin errors++; $display("[TB] FAIL wait_haddr_c%0d: got %h expected 00000108", c, obs_addr[c]); end
            checks++; if (obs_wdata[c] !== 32'hA5A50001) begin errors++; $display("[TB] FAIL wait_hwdata_c%0d: got %h expected a5a50001", c, obs_wdata[c]); end
            checks++; if (obs_trans[c] !== 2'b11) begin errors++; $display("[TB] FAIL wait_htrans_c%0d: got %b expected 11", c, obs_trans[c]); end
        end
        checks++; if (obs_wdata[6] !== 32'hA5A50002) begin errors++; $display("[TB] FAIL wait_hwdata_c6: got %h expected a5a50002", obs_wdata[6]); end
        checks++; if (done_cyc !== 8) begin errors++; $display("[TB] FAIL wait_done_cycle: got %0d expected 8", done_cyc); end
    endtask

    task automatic test_boundary();
        logic [1:0]  exp_tr [4];
        logic [31:0] exp_ad [4];
        exp_tr = '{2'b10, 2'b11, 2'b10, 2'b11};
        exp_ad = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
        run_op(32'h3F8, 16'd4, 32'h12345678, 1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            checks++; if (obs_trans[i+1] !== exp_tr[i]) begin errors++; $display("[TB] FAIL kb_htrans%0d: got %b expected %b", i, obs_trans[i+1], exp_tr[i]); end
            checks++; if (obs_addr[i+1] !== exp_ad[i]) begin errors++; $display("[TB] FAIL kb_haddr%0d: got %h expected %h", i, obs_addr[i+1], exp_ad[i]); end
            checks++; if (obs_wdata[i+2] !== 32'h12345678) begin errors++; $display("[TB] FAIL kb_hwdata%0d: got %h expected 12345678", i, obs_wdata[i+2]); end
        end
    endtask

    task automatic test_verify();
        bad_addr = 32'h108;
        run_op(32'h100, 16'd4, 32'hA5A50000, 1'b1, 1'b1, -1);
        checks++; if ({obs_trans[6], obs_write[6]} !== 3'b100) begin errors++; $display("[TB] FAIL vfy_read_nonseq: got %b expected 100", {obs_trans[6], obs_write[6]}); end
        checks++; if (obs_addr[6] !== 32'h100) begin errors++; $display("[TB] FAIL vfy_read_addr: got %h expected 00000100", obs_addr[6]); end
        checks++; if (obs_trans[7] !== 2'b11) begin errors++; $display("[TB] FAIL vfy_read_seq: got %b expected 11", obs_trans[7]); end
        checks++; if ({err_cmp, err_bus} !== 2'b10) begin errors++; $display("[TB] FAIL vfy_errs: got %b expected 10", {err_cmp, err_bus}); end
        checks++; if (fail_addr !== 32'h108) begin errors++; $display("[TB] FAIL vfy_fail_addr: got %h expected 00000108", fail_addr); end
        checks++; if (fail_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL vfy_fail_data: got %h expected deadbeef", fail_data); end
        checks++; if (done_cyc !== 11) begin errors++; $display("[TB] FAIL vfy_done_cycle: got %0d expected 11", done_cyc); end
        bad_addr = 32'hFFFF_FFFF;
        run_op(32'h100, 16'd3, 32'h55AA0000, 1'b1, 1'b0, -1);
        checks++; if ({err_cmp, err_bus} !== 2'b00) begin errors++; $display("[TB] FAIL vfy_clean_errs: got %b expected 00", {err_cmp, err_bus}); end
        checks++; if (fail_addr !== 32'h0) begin errors++; $display("[TB] FAIL vfy_clean_fail_addr: got %h expected 0", fail_addr); end
        checks++; if (done_cyc !== 9) begin errors++; $display("[TB] FAIL vfy_clean_done_cycle: got %0d expected 9", done_cyc); end
    endtask

    task automatic test_bus_error();
        int active;
        rdy_plan[3] = 1'b0; resp_plan[3] = 2'b01;
        rdy_plan[4] = 1'b1; resp_plan[4] = 2'b01;
        run_op(32'h200, 16'd4, 32'h0, 1'b0, 1'b1, -1);
        active = 0;
        for (int c = 4; c < NCYC; c++) if (obs_trans[c] !== 2'b00) active++;
        checks++; if (obs_trans[4] !== 2'b00) begin errors++; $display("[TB] FAIL berr_cancel: got %b expected 00", obs_trans[4]); end
        checks++; if (active !== 0) begin errors++; $display("[TB] FAIL berr_no_more_xfers: got %0d active cycles expected 0", active); end
        checks++; if ({err_bus, err_cmp} !== 2'b10) begin errors++; $display("[TB] FAIL berr_errs: got %b expected 10", {err_bus, err_cmp}); end
        checks++; if (fail_addr !== 32'h204) begin errors++; $display("[TB] FAIL berr_fail_addr: got %h expected 00000204", fail_addr); end
        checks++; if (fail_data !== 32'h0) begin errors++; $display("[TB] FAIL berr_fail_data: got %h expected 0", fail_data); end
        checks++; if (done_cyc !== 4) begin errors++; $display("[TB] FAIL berr_done_cycle: got %0d expected 4", done_cyc); end
    endtask

    task automatic test_zero_words();
        int active;
        run_op(32'h100, 16'd0, 32'h1, 1'b1, 1'b1, -1);
        active = 0;
        for (int c = 1; c < NCYC; c++) if (obs_trans[c] !== 2'b00) active++;
        checks++; if (done_cyc !== 1) begin errors++; $display("[TB] FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
        checks++; if (active !== 0) begin errors++; $display("[TB] FAIL zero_bus_idle: got %0d active cycles expected 0", active); end
        checks++; if (obs_busy[1] !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %b expected 0", obs_busy[1]); end
    endtask

    task automatic test_reset_mid_burst();
        int done_seen;
        int active;
        @(negedge HCLK);
        base_addr = 32'h0; num_words = 16'd8; seed = 32'h1; verify = 1'b1; incr = 1'b1; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_busy_before: got %b expected 1", busy); end
        repeat (2) @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_htrans: got %b expected 00", HTRANS); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if ({HADDR, HWDATA} !== 64'h0) begin errors++; $display("[TB] FAIL rst_mid_bus: got %h expected 0", {HADDR, HWDATA}); end
        HRESET = 1'b0;
        done_seen = 0; active = 0;
        for (int c = 0; c < 8; c++) begin
            if (done === 1'b1) done_seen++;
            if (HTRANS !== 2'b00) active++;
            @(negedge HCLK);
        end
        checks++; if (done_seen !== 0) begin errors++; $display("[TB] FAIL rst_mid_no_done: got %0d pulses expected 0", done_seen); end
        checks++; if (active !== 0) begin errors++; $display("[TB] FAIL rst_mid_idle_after: got %0d active cycles expected 0", active); end
    endtask

    task automatic test_start_while_busy();
        int active;
        run_op(32'h100, 16'd4, 32'hA5A50000, 1'b0, 1'b1, 2);
        active = 0;
        for (int c = 7; c < NCYC; c++) if (obs_trans[c] !== 2'b00) active++;
        checks++; if (obs_addr[3] !== 32'h108) begin errors++; $display("[TB] FAIL busy_start_addr3: got %h expected 00000108", obs_addr[3]); end
        checks++; if (obs_addr[4] !== 32'h10C) begin errors++; $display("[TB] FAIL busy_start_addr4: got %h expected 0000010c", obs_addr[4]); end
        checks++; if (done_cyc !== 6) begin errors++; $display("[TB] FAIL busy_start_done_cycle: got %0d expected 6", done_cyc); end
        checks++; if (active !== 0) begin errors++; $display("[TB] FAIL busy_start_no_rerun: got %0d active cycles expected 0", active); end
    endtask

    initial begin
        HRESET = 1'b1; start = 1'b0; verify = 1'b0; incr = 1'b0;
        base_addr = '0; num_words = '0; seed = '0;
        HREADY = 1'b1; HRESP = 2'b00;
        bad_addr = 32'hFFFF_FFFF;
        done_cyc = -1;
        clear_plan();
        $display("[TB] starting ahbl_mem_init_master bench");
        test_reset();
        test_fill();
        test_wait_states();
        test_boundary();
        test_verify();
        test_bus_error();
        test_zero_words();
        test_reset_mid_burst();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
